// File: rtl/voice_allocator.sv
// voice_allocator: maps note-on/note-off events onto a fixed bank of tone voices,
// steals voices when the bank is full and ramps released voices down to silence.
module voice_allocator #(
  parameter int unsigned NUM_VOICES   = 4,
  parameter int unsigned RELEASE_DIV  = 40000,
  parameter int unsigned RELEASE_STEP = 4,
  parameter int unsigned AGE_W        = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      evValid,
  output logic                      evReady,
  input  logic                      evNoteOn,
  input  logic [15:0]               evTuneWord,
  input  logic [7:0]                evVolume,
  input  logic                      panic,
  output logic [24*NUM_VOICES-1:0]  notePackets,
  output logic [NUM_VOICES-1:0]     voiceBusy
);

  localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int unsigned DIV_W = (RELEASE_DIV > 1) ? $clog2(RELEASE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RELEASE_DIV - 1);
  localparam logic [AGE_W-1:0] AGE_MAX  = '1;
  localparam logic [7:0]       STEP     = (RELEASE_STEP > 255) ? 8'hFF : 8'(RELEASE_STEP);

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_COMMIT} fsm_t;
  typedef enum logic [1:0] {V_FREE, V_HELD, V_RELEASING} vstate_t;
  typedef enum logic [1:0] {OP_ON, OP_OFF, OP_DROP} op_t;

  fsm_t state_q, state_d;

  vstate_t          vst_q  [NUM_VOICES];
  vstate_t          vst_d  [NUM_VOICES];
  logic [15:0]      tune_q [NUM_VOICES];
  logic [15:0]      tune_d [NUM_VOICES];
  logic [7:0]       vol_q  [NUM_VOICES];
  logic [7:0]       vol_d  [NUM_VOICES];
  logic [AGE_W-1:0] age_q  [NUM_VOICES];
  logic [AGE_W-1:0] age_d  [NUM_VOICES];

  logic [24*NUM_VOICES-1:0] pkt_d;
  logic [NUM_VOICES-1:0]    busy_d;

  logic [DIV_W-1:0] presc_q;
  logic             tick;

  op_t         ev_op, op_q;
  logic [15:0] ev_tune_q;
  logic [7:0]  ev_vol_q;

  logic             on_hit, off_hit, free_hit, rel_hit, held_hit;
  logic [IDX_W-1:0] on_idx, off_idx, free_idx, rel_idx, held_idx;
  logic [AGE_W-1:0] rel_age, held_age;
  logic             srch_ok, tgt_ok_q;
  logic [IDX_W-1:0] srch_idx, tgt_q;

  // Event FSM
  always_ff @(posedge clk) begin
    if (reset || panic) state_q <= S_IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    evReady = 1'b0;
    case (state_q)
      S_IDLE: begin
        evReady = 1'b1;
        if (evValid) state_d = S_SEARCH;
      end
      S_SEARCH: state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // A zero-volume note-on is a note-off; a zero tune word carries no pitch.
  always_comb begin
    if (!evNoteOn || evVolume == '0) ev_op = OP_OFF;
    else if (evTuneWord == '0)       ev_op = OP_DROP;
    else                             ev_op = OP_ON;
  end

  always_ff @(posedge clk) begin
    if (reset || panic) begin
      op_q      <= OP_DROP;
      ev_tune_q <= '0;
      ev_vol_q  <= '0;
      tgt_q     <= '0;
      tgt_ok_q  <= 1'b0;
    end else begin
      if (state_q == S_IDLE && evValid) begin
        op_q      <= ev_op;
        ev_tune_q <= evTuneWord;
        ev_vol_q  <= evVolume;
      end
      if (state_q == S_SEARCH) begin
        tgt_q    <= srch_idx;
        tgt_ok_q <= srch_ok;
      end
    end
  end

  // Candidate scan: first match wins for index priority, strict > keeps lowest index on age ties
  always_comb begin
    on_hit   = 1'b0; on_idx   = '0;
    off_hit  = 1'b0; off_idx  = '0;
    free_hit = 1'b0; free_idx = '0;
    rel_hit  = 1'b0; rel_idx  = '0; rel_age  = '0;
    held_hit = 1'b0; held_idx = '0; held_age = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      if (vst_q[i] != V_FREE && tune_q[i] == ev_tune_q && !on_hit) begin
        on_hit = 1'b1;
        on_idx = IDX_W'(i);
      end
      if (vst_q[i] == V_HELD && tune_q[i] == ev_tune_q && !off_hit) begin
        off_hit = 1'b1;
        off_idx = IDX_W'(i);
      end
      if (vst_q[i] == V_FREE && !free_hit) begin
        free_hit = 1'b1;
        free_idx = IDX_W'(i);
      end
      if (vst_q[i] == V_RELEASING && (!rel_hit || age_q[i] > rel_age)) begin
        rel_hit = 1'b1;
        rel_idx = IDX_W'(i);
        rel_age = age_q[i];
      end
      if (vst_q[i] == V_HELD && (!held_hit || age_q[i] > held_age)) begin
        held_hit = 1'b1;
        held_idx = IDX_W'(i);
        held_age = age_q[i];
      end
    end

    srch_ok  = 1'b0;
    srch_idx = '0;
    case (op_q)
      OP_ON: begin
        srch_ok = 1'b1;
        if (on_hit)        srch_idx = on_idx;
        else if (free_hit) srch_idx = free_idx;
        else if (rel_hit)  srch_idx = rel_idx;
        else               srch_idx = held_idx;
      end
      OP_OFF: begin
        srch_ok  = off_hit;
        srch_idx = off_idx;
      end
      default: begin
        srch_ok  = 1'b0;
        srch_idx = '0;
      end
    endcase
  end

  assign tick = (presc_q == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset)     presc_q <= '0;
    else if (tick) presc_q <= '0;
    else           presc_q <= presc_q + 1'b1;
  end

  // Release ramp is applied first so a same-edge COMMIT overwrites its target afterwards
  always_comb begin
    vst_d  = vst_q;
    tune_d = tune_q;
    vol_d  = vol_q;
    age_d  = age_q;
    pkt_d  = '0;
    busy_d = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      if (tick && vst_q[i] == V_RELEASING) begin
        vol_d[i] = (vol_q[i] > STEP) ? vol_q[i] - STEP : '0;
        if (vol_d[i] == '0) vst_d[i] = V_FREE;
      end
    end
    if (state_q == S_COMMIT && tgt_ok_q) begin
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        if (IDX_W'(i) == tgt_q) begin
          if (op_q == OP_ON) begin
            vst_d[i]  = V_HELD;
            tune_d[i] = ev_tune_q;
            vol_d[i]  = ev_vol_q;
            age_d[i]  = '0;
          end else begin
            vst_d[i] = V_RELEASING;
          end
        end else if (op_q == OP_ON && vst_q[i] != V_FREE && age_q[i] != AGE_MAX) begin
          age_d[i] = age_q[i] + 1'b1;
        end
      end
    end
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      busy_d[i] = (vst_d[i] != V_FREE);
      if (vst_d[i] != V_FREE) pkt_d[24*i +: 24] = {tune_d[i], vol_d[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset || panic) begin
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        vst_q[i]  <= V_FREE;
        tune_q[i] <= '0;
        vol_q[i]  <= '0;
        age_q[i]  <= '0;
      end
      notePackets <= '0;
      voiceBusy   <= '0;
    end else begin
      vst_q       <= vst_d;
      tune_q      <= tune_d;
      vol_q       <= vol_d;
      age_q       <= age_d;
      notePackets <= pkt_d;
      voiceBusy   <= busy_d;
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed scenarios plus random events, every cycle compared
// against a cycle-level reference model built from the allocation rules.
module tb_voice_allocator;

  localparam int NV   = 4;
  localparam int DIV  = 4;
  localparam int STEP = 'h40;
  localparam int AW   = 3;
  localparam int AMAX = (1 << AW) - 1;

  logic            clk = 1'b0;
  logic            reset, evValid, evReady, evNoteOn, panic;
  logic [15:0]     evTuneWord;
  logic [7:0]      evVolume;
  logic [24*NV-1:0] notePackets;
  logic [NV-1:0]   voiceBusy;

  voice_allocator #(
    .NUM_VOICES  (NV),
    .RELEASE_DIV (DIV),
    .RELEASE_STEP(STEP),
    .AGE_W       (AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .evValid    (evValid),
    .evReady    (evReady),
    .evNoteOn   (evNoteOn),
    .evTuneWord (evTuneWord),
    .evVolume   (evVolume),
    .panic      (panic),
    .notePackets(notePackets),
    .voiceBusy  (voiceBusy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: voice kind 0 = free, 1 = held, 2 = releasing
  int m_st [NV];
  int m_tune [NV];
  int m_vol [NV];
  int m_age [NV];
  int m_cnt   = 0;
  int m_phase = 0;  // cycles into the current event: 0 idle, 1 deciding, 2 writing
  int m_kind  = 2;  // 0 note-on, 1 note-off, 2 ignored
  int m_tw    = 0;
  int m_vv    = 0;
  int m_tgt   = -1;

  function automatic void m_clear();
    for (int i = 0; i < NV; i++) begin
      m_st[i] = 0; m_tune[i] = 0; m_vol[i] = 0; m_age[i] = 0;
    end
  endfunction

  // Lowest key wins; the key encodes rule rank, then age (older first), then index.
  function automatic int choose();
    int best = -1;
    int bestkey = 0;
    int key;
    for (int i = 0; i < NV; i++) begin
      key = -1;
      if (m_kind == 0) begin
        if (m_st[i] != 0 && m_tune[i] == m_tw) key = i;
        else if (m_st[i] == 0)                 key = 100 + i;
        else if (m_st[i] == 2)                 key = 200 + (AMAX - m_age[i]) * NV + i;
        else                                   key = 10000 + (AMAX - m_age[i]) * NV + i;
      end else if (m_kind == 1) begin
        if (m_st[i] == 1 && m_tune[i] == m_tw) key = i;
      end
      if (key >= 0 && (best < 0 || key < bestkey)) begin
        best = i;
        bestkey = key;
      end
    end
    return best;
  endfunction

  function automatic void model_step();
    bit tick;
    bit commit;
    int pre [NV];
    tick = (m_cnt == DIV - 1);
    if (reset) begin
      m_clear();
      m_cnt = 0;
      m_phase = 0;
      return;
    end
    m_cnt = tick ? 0 : m_cnt + 1;
    if (panic) begin
      m_clear();
      m_phase = 0;
      return;
    end
    pre = m_st;
    commit = (m_phase == 2) && (m_tgt >= 0);
    if (m_phase == 1) m_tgt = choose();
    for (int i = 0; i < NV; i++) begin
      if (tick && m_st[i] == 2 && !(commit && i == m_tgt)) begin
        m_vol[i] = (m_vol[i] > STEP) ? m_vol[i] - STEP : 0;
        if (m_vol[i] == 0) m_st[i] = 0;
      end
    end
    if (commit) begin
      if (m_kind == 0) begin
        for (int i = 0; i < NV; i++) begin
          if (i == m_tgt) begin
            m_st[i] = 1; m_tune[i] = m_tw; m_vol[i] = m_vv; m_age[i] = 0;
          end else if (pre[i] != 0 && m_age[i] < AMAX) begin
            m_age[i]++;
          end
        end
      end else begin
        m_st[m_tgt] = 2;
      end
    end
    case (m_phase)
      0: if (evValid) begin
        m_tw = int'(evTuneWord);
        m_vv = int'(evVolume);
        if (!evNoteOn || evVolume == 0) m_kind = 1;
        else if (evTuneWord == 0)       m_kind = 2;
        else                            m_kind = 0;
        m_phase = 1;
      end
      1: m_phase = 2;
      default: m_phase = 0;
    endcase
  endfunction

  function automatic logic [24*NV-1:0] exp_pk();
    logic [24*NV-1:0] r = '0;
    for (int i = 0; i < NV; i++)
      if (m_st[i] != 0) r[24*i +: 24] = {16'(m_tune[i]), 8'(m_vol[i])};
    return r;
  endfunction

  function automatic logic [NV-1:0] exp_busy();
    logic [NV-1:0] r = '0;
    for (int i = 0; i < NV; i++) r[i] = (m_st[i] != 0);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("packets", notePackets, exp_pk());
    chk("busy", voiceBusy, exp_busy());
    chk("ready", evReady, (m_phase == 0));
  endtask

  task automatic send(input bit on, input int tw, input int vv);
    int n = 0;
    bit was_idle;
    evValid = 1'b1; evNoteOn = on; evTuneWord = 16'(tw); evVolume = 8'(vv);
    forever begin
      was_idle = (m_phase == 0) && !panic && !reset;
      cycle();
      if (was_idle) break;
      n++;
      if (n > 8) begin
        checks++;
        errors++;
        $error("FAIL handshake_timeout: observed no handshake expected handshake within 8 cycles");
        break;
      end
    end
    evValid = 1'b0;
  endtask

  task automatic event_full(input bit on, input int tw, input int vv);
    send(on, tw, vv);
    cycle();
    cycle();
  endtask

  int gap, rtw, rvv;
  bit ron;

  initial begin
    m_clear();
    reset = 1'b1; panic = 1'b0; evValid = 1'b0; evNoteOn = 1'b0;
    evTuneWord = '0; evVolume = '0;
    cycle();
    cycle();
    reset = 1'b0;
    chk("reset_packets", notePackets, '0);
    chk("reset_busy", voiceBusy, '0);
    chk("reset_ready", evReady, 1'b1);

    // Fill all four voices
    event_full(1, 'h0100, 'h80);
    event_full(1, 'h0200, 'h80);
    event_full(1, 'h0300, 'h80);
    event_full(1, 'h0400, 'h80);
    chk("fill_packets", notePackets, 96'h040080_030080_020080_010080);
    chk("fill_busy", voiceBusy, 4'b1111);

    // Oldest held voice is stolen
    event_full(1, 'h0500, 'h80);
    chk("steal_oldest", notePackets, 96'h040080_030080_020080_050080);

    // Release ramp frees voice 1
    send(0, 'h0200, 0);
    repeat (12) cycle();
    chk("release_free_pkt", notePackets[47:24], 24'h0);
    chk("release_free_busy", voiceBusy, 4'b1101);

    // Releasing voice preferred over older held voices, then retrigger
    event_full(1, 'h0200, 'h80);
    event_full(0, 'h0300, 0);
    event_full(1, 'h0600, 'h80);
    chk("steal_releasing", notePackets[71:48], 24'h060080);
    event_full(0, 'h0600, 0);
    event_full(1, 'h0600, 'h70);
    chk("retrigger", notePackets[71:48], 24'h060070);
    chk("retrigger_busy", voiceBusy, 4'b1111);

    // Classification corners
    event_full(1, 'h0400, 0);
    event_full(0, 'h0777, 'h10);
    event_full(1, 0, 'h50);

    // panic while the event is being written
    send(1, 'h0123, 'h55);
    cycle();
    panic = 1'b1;
    cycle();
    panic = 1'b0;
    chk("panic_packets", notePackets, '0);
    chk("panic_busy", voiceBusy, '0);
    chk("panic_ready", evReady, 1'b1);

    // Random traffic
    for (int k = 0; k < 300; k++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) cycle();
      if ($urandom_range(0, 39) == 0) begin
        panic = 1'b1;
        cycle();
        panic = 1'b0;
      end
      rtw = ($urandom_range(0, 7) == 0) ? 0 : 'h100 * int'($urandom_range(1, 6));
      rvv = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
      ron = ($urandom_range(0, 9) < 7);
      send(ron, rtw, rvv);
    end
    repeat (3) cycle();

    // Reset coinciding with a release tick
    event_full(1, 'h0100, 'h80);
    event_full(1, 'h0200, 'hC0);
    event_full(0, 'h0100, 0);
    for (int n = 0; n < DIV + 1 && m_cnt != DIV - 1; n++) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("tick_reset_packets", notePackets, '0);
    chk("tick_reset_busy", voiceBusy, '0);
    chk("tick_reset_ready", evReady, 1'b1);
    event_full(1, 'h0300, 'h80);
    send(0, 'h0300, 0);
    repeat (12) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no completion expected completion before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
